pix_run_scheduler: RTL and testbench

Schedules runs of the PIX test-structure sequencer. Accepts either the pulse-generator trigger (active-low LEMO/DIO input) or a software start from the SPI command decoder. Applies a programmable trigger delay and emits the single-cycle `run_sequencer` pulse. Also generates internal bursts of N runs at a programmable period, gated on the sequencer's `ready_flag`. Sits between the command decoder / trigger input and `sequencer_for_PIX_V1_SW_28_10_19`.

---
 rtl/pix_run_scheduler.sv | 174 +++++++++++++++++
 tb/tb_pix_run_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pix_run_scheduler.sv
// Run scheduler for the PIX test-structure sequencer: accepts external or
// software triggers, applies a trigger delay and generates internal run bursts.
module pix_run_scheduler #(
  parameter int DELAY_W       = 10,
  parameter int CNT_W         = 16,
  parameter int START_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic               start,
  input  logic               ext_trigger_n,
  input  logic [DELAY_W-1:0] trigger_delay,
  input  logic [CNT_W-1:0]   burst_count,
  input  logic [CNT_W-1:0]   burst_period,
  input  logic               clear_counters,
  input  logic               seq_ready,
  output logic               run_sequencer,
  output logic               busy,
  output logic               burst_done,
  output logic [CNT_W-1:0]   run_count,
  output logic [CNT_W-1:0]   missed_count
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DELAY      = 3'd1;
  localparam logic [2:0] S_FIRE       = 3'd2;
  localparam logic [2:0] S_WAIT_START = 3'd3;
  localparam logic [2:0] S_WAIT_DONE  = 3'd4;
  localparam logic [2:0] S_PERIOD     = 3'd5;

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

  // Handshake: run_sequencer is a one-cycle request to the sequencer; the
  // sequencer acknowledges by dropping seq_ready and completes by raising it.

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic               sync1;
  logic               sync2;
  logic               sync3;
  logic               ext_fall;
  logic [DELAY_W-1:0] dcnt;
  logic [CNT_W-1:0]   pcnt;
  logic [CNT_W-1:0]   rem;
  logic [CNT_W-1:0]   lat_count;
  logic [CNT_W-1:0]   lat_period;
  logic               lat_mode;
  logic [TW-1:0]      tcnt;

  logic               idle;
  logic               trig_m0;
  logic               trig_m1;
  logic               accept;
  logic               miss;
  logic               burst_last;
  logic [CNT_W-1:0]   per_src;
  logic [CNT_W-1:0]   per_load;

  // Synchronizer flops reset high so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      sync3    <= 1'b1;
      ext_fall <= 1'b0;
    end else begin
      sync1    <= ext_trigger_n;
      sync2    <= sync1;
      sync3    <= sync2;
      ext_fall <= sync3 & ~sync2;
    end
  end

  assign idle       = (state == S_IDLE);
  assign trig_m0    = ~mode & (ext_fall | start);
  assign trig_m1    = mode & start;
  assign accept     = idle & enable & seq_ready & (trig_m0 | trig_m1);
  assign miss       = (~idle & trig_m0) |
                      (idle & enable & ~seq_ready & (trig_m0 | trig_m1));
  assign burst_last = lat_mode & (lat_count != '0) & (rem == '0);

  // A zero-delay accept goes straight to FIRE, before the period is latched.
  assign per_src  = idle ? burst_period : lat_period;
  assign per_load = (per_src == '0) ? '0 : per_src - CNT_W'(1);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) next_state = (trigger_delay == '0) ? S_FIRE : S_DELAY;
      end
      S_DELAY: begin
        if (!enable)                        next_state = S_IDLE;
        else if (dcnt <= DELAY_W'(1))       next_state = S_FIRE;
      end
      S_FIRE: next_state = S_WAIT_START;
      S_WAIT_START: begin
        if (!seq_ready || tcnt == TO_LAST)  next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (seq_ready) begin
          if (!lat_mode || burst_last || !enable) next_state = S_IDLE;
          else                                    next_state = S_PERIOD;
        end
      end
      S_PERIOD: begin
        if (!enable)                        next_state = S_IDLE;
        else if (pcnt == '0 && seq_ready)   next_state = S_FIRE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= (next_state != S_IDLE);
      burst_done <= (state == S_WAIT_DONE) & seq_ready & burst_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt       <= '0;
      pcnt       <= '0;
      rem        <= '0;
      lat_count  <= '0;
      lat_period <= '0;
      lat_mode   <= 1'b0;
      tcnt       <= '0;
    end else begin
      if (accept) begin
        dcnt       <= trigger_delay;
        lat_mode   <= mode;
        lat_count  <= burst_count;
        lat_period <= burst_period;
        rem        <= burst_count;
      end else if (state == S_DELAY && dcnt != '0) begin
        dcnt <= dcnt - DELAY_W'(1);
      end

      // The period runs from the fire cycle, so a long run absorbs it.
      if (next_state == S_FIRE)  pcnt <= per_load;
      else if (pcnt != '0)       pcnt <= pcnt - CNT_W'(1);

      if (state == S_FIRE && lat_count != '0 && rem != '0)
        rem <= rem - CNT_W'(1);

      if (state == S_WAIT_START) tcnt <= tcnt + TW'(1);
      else                       tcnt <= '0;
    end
  end

  assign run_sequencer = (state == S_FIRE);

  // Status counters saturate; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clear_counters) begin
      run_count    <= '0;
      missed_count <= '0;
    end else begin
      if (state == S_FIRE && run_count != '1)  run_count    <= run_count + CNT_W'(1);
      if (miss && missed_count != '1)          missed_count <= missed_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pix_run_scheduler.sv
// Directed bench for pix_run_scheduler with a small sequencer model and a
// queue of expected fire cycles.
module tb_pix_run_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic        ext_trigger_n = 1'b1;
  logic [9:0]  trigger_delay = '0;
  logic [15:0] burst_count = '0;
  logic [15:0] burst_period = '0;
  logic        clear_counters = 1'b0;
  logic        seq_ready = 1'b1;
  logic        run_sequencer;
  logic        busy;
  logic        burst_done;
  logic [15:0] run_count;
  logic [15:0] missed_count;

  pix_run_scheduler #(.DELAY_W(10), .CNT_W(16), .START_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start),
    .ext_trigger_n(ext_trigger_n), .trigger_delay(trigger_delay),
    .burst_count(burst_count), .burst_period(burst_period),
    .clear_counters(clear_counters), .seq_ready(seq_ready),
    .run_sequencer(run_sequencer), .busy(busy), .burst_done(burst_done),
    .run_count(run_count), .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          fire_cnt = 0;
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  int          seq_len = 0;
  int          model_cnt = 0;
  logic        force_low = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
  endtask

  task automatic ext_pulse(input int n);
    ext_trigger_n = 1'b0;
    wait_cycles(n);
    ext_trigger_n = 1'b1;
  endtask

  // Monitor at +1, sequencer model at +2 after each edge.
  always @(posedge clk) begin
    #1;
    if (run_sequencer) begin
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
      check_eq("fire_cycle", cyc, mon_exp);
      check_eq("seq_ready_at_fire", {31'd0, seq_ready}, 32'd1);
      fire_cnt++;
    end
    if (burst_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    #1;
    if (model_cnt > 0) model_cnt--;
    if (run_sequencer) model_cnt = seq_len;
    seq_ready = !force_low && (model_cnt == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    int          d0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(1);
    check_eq("rst_run_seq", {31'd0, run_sequencer}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_burst_done", {31'd0, burst_done}, 0);
    check_eq("rst_run_count", run_count, 0);
    check_eq("rst_missed", missed_count, 0);

    // Mode 0 external trigger, delay 36: fire 39 cycles after the first low sample.
    enable = 1'b1; mode = 1'b0; trigger_delay = 10'd36; seq_len = 10;
    a = cyc + 1;
    exp_q.push_back(a + 39);
    ext_pulse(5);
    wait_until(a + 70);
    check_eq("t1_q_empty", exp_q.size(), 0);
    check_eq("t1_run_count", run_count, 1);
    check_eq("t1_missed", missed_count, 0);

    // Mode 0 triggers while the sequencer is busy are missed, not fired.
    trigger_delay = 10'd5; seq_len = 200;
    a = cyc;
    exp_q.push_back(a + 6);
    start_pulse();
    wait_until(a + 30);
    check_eq("t2_busy_wait", {31'd0, busy}, 1);
    ext_pulse(3);
    wait_until(a + 60);
    start_pulse();
    wait_until(a + 220);
    check_eq("t2_q_empty", exp_q.size(), 0);
    check_eq("t2_missed", missed_count, 2);
    check_eq("t2_run_count", run_count, 2);
    check_eq("t2_busy_idle", {31'd0, busy}, 0);

    clear_counters = 1'b1;
    wait_cycles(1);
    clear_counters = 1'b0;
    check_eq("clr_run_count", run_count, 0);
    check_eq("clr_missed", missed_count, 0);

    // Burst of 3, period 100, short runs: fires exactly 100 apart.
    mode = 1'b1; burst_count = 16'd3; burst_period = 16'd100; trigger_delay = 10'd2; seq_len = 20;
    a = cyc;
    d0 = done_cnt;
    exp_q.push_back(a + 3); exp_q.push_back(a + 103); exp_q.push_back(a + 203);
    start_pulse();
    wait_until(a + 150);
    start_pulse();
    wait_until(a + 240);
    check_eq("t3_q_empty", exp_q.size(), 0);
    check_eq("t3_done_cnt", done_cnt - d0, 1);
    check_eq("t3_done_cyc", done_cyc, a + 224);
    check_eq("t3_run_count", run_count, 3);
    check_eq("t3_missed", missed_count, 0);

    // Runs longer than the period: next fire waits for seq_ready.
    burst_count = 16'd2; burst_period = 16'd10; trigger_delay = 10'd0; seq_len = 50;
    a = cyc;
    d0 = done_cnt;
    exp_q.push_back(a + 1); exp_q.push_back(a + 53);
    start_pulse();
    wait_until(a + 130);
    check_eq("t4_q_empty", exp_q.size(), 0);
    check_eq("t4_done_cnt", done_cnt - d0, 1);
    check_eq("t4_done_cyc", done_cyc, a + 104);
    check_eq("t4_run_count", run_count, 5);

    // Continuous burst, enable dropped in PERIOD after the fifth fire.
    burst_count = 16'd0; burst_period = 16'd30; seq_len = 5;
    a = cyc;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(a + 1 + 30 * i);
    start_pulse();
    wait_until(a + 136);
    check_eq("t5_busy_period", {31'd0, busy}, 1);
    enable = 1'b0;
    wait_until(a + 200);
    check_eq("t5_q_empty", exp_q.size(), 0);
    check_eq("t5_no_done", done_cnt - d0, 0);
    check_eq("t5_busy", {31'd0, busy}, 0);
    check_eq("t5_run_count", run_count, 10);

    // Trigger with seq_ready low is missed; disabled and mode-1 ext are ignored.
    enable = 1'b1; mode = 1'b0; force_low = 1'b1;
    wait_cycles(2);
    start_pulse();
    wait_cycles(5);
    check_eq("t6_missed_notready", missed_count, 1);
    check_eq("t6_busy_notready", {31'd0, busy}, 0);
    force_low = 1'b0; enable = 1'b0;
    wait_cycles(2);
    start_pulse();
    ext_pulse(3);
    wait_cycles(8);
    check_eq("t6_missed_disabled", missed_count, 1);
    enable = 1'b1; mode = 1'b1;
    ext_pulse(3);
    wait_cycles(8);
    check_eq("t6_busy_m1_ext", {31'd0, busy}, 0);
    check_eq("t6_missed_m1_ext", missed_count, 1);
    check_eq("t6_run_count", run_count, 10);

    // Reset during DELAY cancels the pending fire.
    mode = 1'b0; trigger_delay = 10'd20;
    start_pulse();
    wait_cycles(5);
    check_eq("t7_busy_delay", {31'd0, busy}, 1);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check_eq("t7_run_seq", {31'd0, run_sequencer}, 0);
    check_eq("t7_busy", {31'd0, busy}, 0);
    check_eq("t7_burst_done", {31'd0, burst_done}, 0);
    check_eq("t7_run_count", run_count, 0);
    check_eq("t7_missed", missed_count, 0);
    wait_cycles(40);
    check_eq("t7_q_empty", exp_q.size(), 0);

    // seq_ready stuck high: WAIT_START times out after 4 cycles.
    trigger_delay = 10'd0; seq_len = 0;
    a = cyc;
    exp_q.push_back(a + 1);
    start_pulse();
    wait_until(a + 6);
    check_eq("t8_busy_last", {31'd0, busy}, 1);
    wait_until(a + 7);
    check_eq("t8_busy_idle", {31'd0, busy}, 0);
    check_eq("t8_run_count", run_count, 1);

    // clear_counters in the fire cycle wins over the increment.
    trigger_delay = 10'd3; seq_len = 5;
    a = cyc;
    exp_q.push_back(a + 4);
    start_pulse();
    wait_until(a + 4);
    clear_counters = 1'b1;
    wait_cycles(1);
    clear_counters = 1'b0;
    wait_until(a + 30);
    check_eq("t9_q_empty", exp_q.size(), 0);
    check_eq("t9_run_count", run_count, 0);
    check_eq("t9_fire_total", fire_cnt, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
